// File: rtl/dop_pkg.sv
// Shared DoP constants: marker bytes, idle byte, marker width.
// Also a byte-replication helper for building idle payloads.
package dop_pkg;

  localparam int MW = 8;

  localparam logic [MW-1:0] DOP_MARK_A = 8'h05;
  localparam logic [MW-1:0] DOP_MARK_B = 8'hFA;
  localparam logic [MW-1:0] DSD_IDLE   = 8'h69;

  typedef enum logic {
    MARK_A = 1'b0,
    MARK_B = 1'b1
  } mark_e;

  function automatic logic [255:0] rep_byte(
    input logic [7:0] b
  );
    logic [255:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i*8 +: 8] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_tx.sv
// I2S master transmitter: frame counter, lrck, word load at frame end,
// MSB-first serialisation with a one-bclk delay slot in I2S mode.
module i2s_tx
  import dop_pkg::*;
#(
  parameter int          DW   = 24,
  parameter int          SW   = 32,
  parameter string       TYPE = "I2S",
  parameter logic [DW-1:0] INIT = '0
) (
  input  logic          bclk,
  input  logic          rst,
  input  logic [DW-1:0] word_l,
  input  logic [DW-1:0] word_r,
  output logic          frame_end,
  output logic          lrck,
  output logic          data
);

  localparam int FW  = 2 * SW;
  localparam int CW  = $clog2(FW);
  localparam int IW  = $clog2(DW);
  localparam int DLY = (TYPE == "I2S") ? 1 : 0;

  logic [CW-1:0] fcnt;
  logic [CW-1:0] fnext;
  logic [CW-1:0] pnext;
  logic [DW-1:0] tx_l;
  logic [DW-1:0] tx_r;
  logic [DW-1:0] cur;
  logic          right;
  logic          bit_n;
  int            pos;

  // Outputs are registered from the next counter value, so lrck and
  // data always line up with the fcnt they are reported against.
  always_comb begin
    frame_end = (fcnt == CW'(FW - 1));
    fnext     = frame_end ? '0 : fcnt + 1'b1;
    right     = (fnext >= CW'(SW));
    pnext     = right ? fnext - CW'(SW) : fnext;
    cur       = right ? tx_r : tx_l;
    pos       = int'(pnext) - DLY;
    bit_n     = 1'b0;
    if (pos >= 0 && pos < DW) begin
      bit_n = cur[IW'(DW - 1 - pos)];
    end
  end

  always_ff @(posedge bclk) begin
    if (!rst) begin
      fcnt <= '0;
      lrck <= 1'b0;
      data <= 1'b0;
      tx_l <= INIT;
      tx_r <= INIT;
    end else begin
      fcnt <= fnext;
      lrck <= right;
      data <= bit_n;
      if (frame_end) begin
        tx_l <= word_l;
        tx_r <= word_r;
      end
    end
  end

endmodule

// File: rtl/dsd_to_dop.sv
// DSD to DoP packer feeding an I2S master; optional mute input under
// DSD_TO_DOP_MUTE_EN.
module dsd_to_dop
  import dop_pkg::*;
#(
  parameter int         DW   = 16,
  parameter int         SW   = 32,
  parameter logic [7:0] IDLE = DSD_IDLE
) (
  input  logic bclk,
  input  logic rst,
  input  logic dsd_valid_i,
  input  logic dsd_l_i,
  input  logic dsd_r_i,
`ifdef DSD_TO_DOP_MUTE_EN
  input  logic mute,
`endif
  output logic lrck,
  output logic data,
  output logic underrun,
  output logic overrun
);

  localparam int WW = DW + MW;
  localparam int CW = $clog2(DW) + 1;

  localparam logic [DW-1:0] IDLE_PL = DW'(rep_byte(IDLE));
  localparam logic [WW-1:0] INIT    = {DOP_MARK_A, IDLE_PL};

  logic [CW-1:0] cnt;
  logic [DW-1:0] sh_l;
  logic [DW-1:0] sh_r;
  logic [DW-1:0] nxt_l;
  logic [DW-1:0] nxt_r;
  logic [DW-1:0] hold_l;
  logic [DW-1:0] hold_r;
  logic          full;
  mark_e         mark;
  logic [MW-1:0] new_mark;
  logic [WW-1:0] word_l;
  logic [WW-1:0] word_r;
  logic          frame_end;
  logic          copy;
  logic          muted;
  logic          live;

`ifdef DSD_TO_DOP_MUTE_EN
  assign muted = mute;
`else
  assign muted = 1'b0;
`endif

  always_comb begin
    copy     = dsd_valid_i && (cnt == CW'(DW - 1));
    nxt_l    = {sh_l[DW-2:0], dsd_l_i};
    nxt_r    = {sh_r[DW-2:0], dsd_r_i};
    new_mark = (mark == MARK_A) ? DOP_MARK_B : DOP_MARK_A;
    live     = full && !muted;
    word_l   = {new_mark, live ? hold_l : IDLE_PL};
    word_r   = {new_mark, live ? hold_r : IDLE_PL};
  end

  // A copy on the load edge refills holding after the old word is taken,
  // so full stays set and no overrun is flagged.
  always_ff @(posedge bclk) begin
    if (!rst) begin
      cnt      <= '0;
      sh_l     <= '0;
      sh_r     <= '0;
      hold_l   <= '0;
      hold_r   <= '0;
      full     <= 1'b0;
      mark     <= MARK_A;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      underrun <= frame_end && !full && !muted;
      overrun  <= copy && full && !frame_end;
      if (frame_end) begin
        mark <= (mark == MARK_A) ? MARK_B : MARK_A;
      end
      if (dsd_valid_i) begin
        sh_l <= nxt_l;
        sh_r <= nxt_r;
        cnt  <= copy ? '0 : cnt + 1'b1;
      end
      if (copy) begin
        hold_l <= nxt_l;
        hold_r <= nxt_r;
        full   <= 1'b1;
      end else if (frame_end) begin
        full <= 1'b0;
      end
    end
  end

  i2s_tx #(
    .DW   (WW),
    .SW   (SW),
    .TYPE ("I2S"),
    .INIT (INIT)
  ) u_tx (
    .bclk      (bclk),
    .rst       (rst),
    .word_l    (word_l),
    .word_r    (word_r),
    .frame_end (frame_end),
    .lrck      (lrck),
    .data      (data)
  );

endmodule

// File: tb/tb_dsd_to_dop.sv
// Scoreboard bench for dsd_to_dop: expected DoP frames are queued as
// stimulus is planned and compared against deserialised I2S output.
module tb_dsd_to_dop;

  localparam int SW = 32;
  localparam int FW = 2 * SW;
  localparam logic [15:0] IDL = 16'h6969;

  logic bclk = 1'b0;
  logic rst = 1'b0;
  logic dsd_valid_i = 1'b0;
  logic dsd_l_i = 1'b0;
  logic dsd_r_i = 1'b0;
`ifdef DSD_TO_DOP_MUTE_EN
  logic mute = 1'b0;
`endif
  logic lrck;
  logic data;
  logic underrun;
  logic overrun;

  always #5 bclk = ~bclk;

  dsd_to_dop dut (
    .bclk        (bclk),
    .rst         (rst),
    .dsd_valid_i (dsd_valid_i),
    .dsd_l_i     (dsd_l_i),
    .dsd_r_i     (dsd_r_i),
`ifdef DSD_TO_DOP_MUTE_EN
    .mute        (mute),
`endif
    .lrck        (lrck),
    .data        (data),
    .underrun    (underrun),
    .overrun     (overrun)
  );

  // Bench time base: bclk position in frame and frame index since reset.
  int bc = 0;
  int fidx = 0;
  always @(posedge bclk) begin
    if (!rst) begin
      bc   <= 0;
      fidx <= 0;
    end else begin
      bc <= (bc == FW - 1) ? 0 : bc + 1;
      if (bc == FW - 1) fidx <= fidx + 1;
    end
  end

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          ur;
    int          ov;
  } frame_t;

  frame_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic push_frame(input int n, input logic [15:0] pl,
                            input logic [15:0] pr, input int ur,
                            input int ov);
    frame_t e;
    logic [7:0] m;
    m = (n % 2 == 1) ? 8'hFA : 8'h05;
    e.l = {m, pl};
    e.r = {m, pr};
    e.ur = ur;
    e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic sync_frame();
    int guard = 0;
    @(negedge bclk);
    while (bc != 0 && guard < 2 * FW) begin
      @(negedge bclk);
      guard++;
    end
  endtask

  task automatic capture_frame(output frame_t f, output int bad);
    int guard = 0;
    int p;
    bad = 0;
    f.l = '0;
    f.r = '0;
    f.ur = 0;
    f.ov = 0;
    while (bc != 0 && guard < 2 * FW) begin
      @(negedge bclk);
      guard++;
    end
    if (bc != 0) bad++;
    for (int i = 0; i < FW; i++) begin
      if (i > 0) @(negedge bclk);
      p = i % SW;
      if (lrck !== (i >= SW)) bad++;
      if (p >= 1 && p <= 24) begin
        if (i < SW) f.l[24-p] = data;
        else f.r[24-p] = data;
      end else if (data !== 1'b0) begin
        bad++;
      end
      if (underrun === 1'b1) f.ur++;
      if (overrun === 1'b1) f.ov++;
    end
  endtask

  task automatic send_word(input logic [15:0] l, input logic [15:0] r,
                           input int gap, input int dly);
    repeat (dly) @(negedge bclk);
    for (int i = 15; i >= 0; i--) begin
      dsd_valid_i = 1'b1;
      dsd_l_i = l[i];
      dsd_r_i = r[i];
      @(negedge bclk);
      dsd_valid_i = 1'b0;
      repeat (gap - 1) @(negedge bclk);
    end
  endtask

  task automatic test_reset();
    frame_t g;
    frame_t e;
    int bad;
    rst = 1'b0;
    dsd_valid_i = 1'b1;
    dsd_l_i = 1'b1;
    dsd_r_i = 1'b1;
    repeat (3) @(negedge bclk);
    checks++;
    if ({lrck, data, underrun, overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0000",
               {lrck, data, underrun, overrun});
    end
    dsd_valid_i = 1'b0;
    rst = 1'b1;
    push_frame(0, IDL, IDL, 0, 0);
    push_frame(1, IDL, IDL, 1, 0);
    push_frame(2, IDL, IDL, 1, 0);
    for (int k = 0; k < 3; k++) begin
      capture_frame(g, bad);
      e = sb.pop_front();
      checks++;
      if ({g.l, g.r} !== {e.l, e.r}) begin
        failures++;
        $display("FAIL idle_words f%0d: got %h/%h required %h/%h",
                 k, g.l, g.r, e.l, e.r);
      end
      checks++;
      if (g.ur !== e.ur || g.ov !== e.ov) begin
        failures++;
        $display("FAIL idle_flags f%0d: got ur=%0d ov=%0d required ur=%0d ov=%0d",
                 k, g.ur, g.ov, e.ur, e.ov);
      end
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL idle_framing f%0d: got %0d errors required 0", k, bad);
      end
    end
  endtask

  task automatic test_pack();
    frame_t g;
    frame_t e;
    int bad;
    int n0;
    sync_frame();
    n0 = fidx;
    push_frame(n0, IDL, IDL, 1, 0);
    push_frame(n0 + 1, 16'hA5C3, 16'h1234, 0, 0);
    push_frame(n0 + 2, IDL, IDL, 1, 0);
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          capture_frame(g, bad);
          e = sb.pop_front();
          checks++;
          if ({g.l, g.r} !== {e.l, e.r}) begin
            failures++;
            $display("FAIL pack_words f%0d: got %h/%h required %h/%h",
                     k, g.l, g.r, e.l, e.r);
          end
          checks++;
          if (g.ur !== e.ur || g.ov !== e.ov) begin
            failures++;
            $display("FAIL pack_flags f%0d: got ur=%0d ov=%0d required ur=%0d ov=%0d",
                     k, g.ur, g.ov, e.ur, e.ov);
          end
          checks++;
          if (bad !== 0) begin
            failures++;
            $display("FAIL pack_framing f%0d: got %0d errors required 0", k, bad);
          end
        end
      end
      send_word(16'hA5C3, 16'h1234, 4, 0);
    join
  endtask

  task automatic test_overrun();
    frame_t g;
    frame_t e;
    int bad;
    int n0;
    sync_frame();
    n0 = fidx;
    push_frame(n0, IDL, IDL, 1, 1);
    push_frame(n0 + 1, 16'hBEEF, 16'hCAFE, 0, 0);
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          capture_frame(g, bad);
          e = sb.pop_front();
          checks++;
          if ({g.l, g.r} !== {e.l, e.r}) begin
            failures++;
            $display("FAIL ovr_words f%0d: got %h/%h required %h/%h",
                     k, g.l, g.r, e.l, e.r);
          end
          checks++;
          if (g.ur !== e.ur || g.ov !== e.ov) begin
            failures++;
            $display("FAIL ovr_flags f%0d: got ur=%0d ov=%0d required ur=%0d ov=%0d",
                     k, g.ur, g.ov, e.ur, e.ov);
          end
          checks++;
          if (bad !== 0) begin
            failures++;
            $display("FAIL ovr_framing f%0d: got %0d errors required 0", k, bad);
          end
        end
      end
      begin
        send_word(16'h1111, 16'h2222, 2, 0);
        send_word(16'hBEEF, 16'hCAFE, 2, 0);
      end
    join
  endtask

  task automatic test_back_to_back();
    frame_t g;
    frame_t e;
    int bad;
    int n0;
    sync_frame();
    n0 = fidx;
    push_frame(n0, IDL, IDL, 1, 0);
    push_frame(n0 + 1, 16'h1357, 16'h2468, 0, 0);
    push_frame(n0 + 2, 16'hFEDC, 16'h0F1E, 0, 0);
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          capture_frame(g, bad);
          e = sb.pop_front();
          checks++;
          if ({g.l, g.r} !== {e.l, e.r}) begin
            failures++;
            $display("FAIL b2b_words f%0d: got %h/%h required %h/%h",
                     k, g.l, g.r, e.l, e.r);
          end
          checks++;
          if (g.ur !== e.ur || g.ov !== e.ov) begin
            failures++;
            $display("FAIL b2b_flags f%0d: got ur=%0d ov=%0d required ur=%0d ov=%0d",
                     k, g.ur, g.ov, e.ur, e.ov);
          end
          checks++;
          if (bad !== 0) begin
            failures++;
            $display("FAIL b2b_framing f%0d: got %0d errors required 0", k, bad);
          end
        end
      end
      begin
        send_word(16'h1357, 16'h2468, 2, 0);
        send_word(16'hFEDC, 16'h0F1E, 2, 1);
      end
    join
  endtask

  task automatic test_midword_reset();
    frame_t g;
    frame_t e;
    int bad;
    sync_frame();
    for (int i = 0; i < 9; i++) begin
      dsd_valid_i = 1'b1;
      dsd_l_i = 1'b1;
      dsd_r_i = 1'b0;
      @(negedge bclk);
      dsd_valid_i = 1'b0;
      @(negedge bclk);
    end
    rst = 1'b0;
    dsd_valid_i = 1'b1;
    repeat (2) @(negedge bclk);
    checks++;
    if ({lrck, data, underrun, overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_outputs: got %b required 0000",
               {lrck, data, underrun, overrun});
    end
    dsd_valid_i = 1'b0;
    rst = 1'b1;
    push_frame(0, IDL, IDL, 0, 0);
    push_frame(1, 16'h0F0F, 16'h3C3C, 0, 0);
    push_frame(2, IDL, IDL, 1, 0);
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          capture_frame(g, bad);
          e = sb.pop_front();
          checks++;
          if ({g.l, g.r} !== {e.l, e.r}) begin
            failures++;
            $display("FAIL rst_words f%0d: got %h/%h required %h/%h",
                     k, g.l, g.r, e.l, e.r);
          end
          checks++;
          if (g.ur !== e.ur || g.ov !== e.ov) begin
            failures++;
            $display("FAIL rst_flags f%0d: got ur=%0d ov=%0d required ur=%0d ov=%0d",
                     k, g.ur, g.ov, e.ur, e.ov);
          end
          checks++;
          if (bad !== 0) begin
            failures++;
            $display("FAIL rst_framing f%0d: got %0d errors required 0", k, bad);
          end
        end
      end
      send_word(16'h0F0F, 16'h3C3C, 4, 0);
    join
  endtask

`ifdef DSD_TO_DOP_MUTE_EN
  task automatic test_mute();
    frame_t g;
    frame_t e;
    int bad;
    int n0;
    sync_frame();
    n0 = fidx;
    mute = 1'b1;
    push_frame(n0, IDL, IDL, 1, 0);
    push_frame(n0 + 1, IDL, IDL, 0, 0);
    push_frame(n0 + 2, IDL, IDL, 0, 0);
    push_frame(n0 + 3, 16'h7002, 16'h8002, 0, 0);
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          capture_frame(g, bad);
          e = sb.pop_front();
          checks++;
          if ({g.l, g.r} !== {e.l, e.r}) begin
            failures++;
            $display("FAIL mute_words f%0d: got %h/%h required %h/%h",
                     k, g.l, g.r, e.l, e.r);
          end
          checks++;
          if (g.ur !== e.ur || g.ov !== e.ov) begin
            failures++;
            $display("FAIL mute_flags f%0d: got ur=%0d ov=%0d required ur=%0d ov=%0d",
                     k, g.ur, g.ov, e.ur, e.ov);
          end
          checks++;
          if (bad !== 0) begin
            failures++;
            $display("FAIL mute_framing f%0d: got %0d errors required 0", k, bad);
          end
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          if (k == 2) mute = 1'b0;
          send_word(16'h7000 + 16'(k), 16'h8000 + 16'(k), 4, 0);
        end
      end
    join
  endtask
`endif

  initial begin
    test_reset();
    test_pack();
    test_overrun();
    test_back_to_back();
    test_midword_reset();
`ifdef DSD_TO_DOP_MUTE_EN
    test_mute();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
